apb_cmd_initiator: RTL and testbench

- Hardware-side APB3 requester (APB master) that turns single-beat read/write commands from an internal client into APB transactions.
- Drives the APB slave port of a regmst_* block (PCLK/PRESETn, PSEL/PENABLE/PWRITE/PADDR/PWDATA in; PREADY/PRDATA/PSLVERR back).
- Lets on-chip agents, for example a boot sequencer or debug engine, access the register tree without an external bus.
- One transaction outstanding at a time.
- A programmable PREADY timeout converts a hung slave into an error response.

---
 rtl/apb_cmd_initiator.sv | 143 ++++++++++++++
 tb/tb_apb_cmd_initiator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_initiator.sv
// APB3 requester: turns single-beat read/write commands into APB transfers,
// one outstanding at a time, with a PREADY timeout that aborts a hung slave.
module apb_cmd_initiator #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic                 TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  timeout_hit;
  logic                  psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic                  rsp_vld_nxt, rsp_err_nxt, rsp_timeout_nxt;

  assign req_rdy     = (state == IDLE);
  assign busy        = (state != IDLE);
  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_vld) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output; PREADY wins over a same-cycle timeout.
  always_comb begin
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    rsp_vld_nxt     = rsp_vld;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    cnt_nxt         = cnt;
    case (state)
      IDLE: begin
        if (req_vld) begin
          pwrite_nxt  = req_wr;
          paddr_nxt   = req_addr;
          pwdata_nxt  = req_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_vld_nxt     = 1'b1;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          rsp_err_nxt     = PSLVERR;
          rsp_timeout_nxt = 1'b0;
        end else if (timeout_hit) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_vld_nxt     = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_rdy) rsp_vld_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_vld     <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      rsp_vld     <= rsp_vld_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Directed bench for apb_cmd_initiator: the bench plays the APB slave and
// the command client, with hand-computed expectations at each step.
module tb_apb_cmd_initiator;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_vld, req_rdy, req_wr;
  logic [63:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout, busy;
  logic        PSEL, PENABLE, PWRITE;
  logic [63:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_initiator #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic applyStimulus(input logic wr, input logic [63:0] addr,
                               input logic [31:0] wdata);
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    PRESETn = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_rdy = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    #1;
    checkOutput("rst_req_rdy", req_rdy, 1);
    checkOutput("rst_psel", PSEL, 0);
    checkOutput("rst_rsp_vld", rsp_vld, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_paddr", PADDR, 0);
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;
    tick();
    checkOutput("idle_hold_psel", PSEL, 0);
    checkOutput("idle_hold_busy", busy, 0);

    // Write, zero-wait slave
    PREADY = 1'b1;
    applyStimulus(1'b1, 64'h8, 32'hFFFF_FFFF);
    tick();
    req_vld = 1'b0;
    checkOutput("wr_setup_psel", PSEL, 1);
    checkOutput("wr_setup_penable", PENABLE, 0);
    checkOutput("wr_setup_paddr", PADDR, 64'h8);
    checkOutput("wr_setup_pwrite", PWRITE, 1);
    checkOutput("wr_setup_pwdata", PWDATA, 32'hFFFF_FFFF);
    checkOutput("wr_setup_req_rdy", req_rdy, 0);
    checkOutput("wr_setup_busy", busy, 1);
    tick();
    checkOutput("wr_access_penable", PENABLE, 1);
    checkOutput("wr_access_rsp_vld", rsp_vld, 0);
    tick();
    checkOutput("wr_rsp_vld", rsp_vld, 1);
    checkOutput("wr_rsp_err", rsp_err, 0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 0);
    checkOutput("wr_rsp_timeout", rsp_timeout, 0);
    checkOutput("wr_rsp_psel", PSEL, 0);
    checkOutput("wr_rsp_penable", PENABLE, 0);
    checkOutput("wr_rsp_pwdata_kept", PWDATA, 32'hFFFF_FFFF);
    rsp_rdy = 1'b1;
    tick();
    checkOutput("wr_done_rsp_vld", rsp_vld, 0);
    checkOutput("wr_done_req_rdy", req_rdy, 1);

    // Read with 3 wait states
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    applyStimulus(1'b0, 64'h20, 32'h0);
    tick();
    req_vld = 1'b0;
    tick();
    checkOutput("rd_access1_penable", PENABLE, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rd_wait_rsp_vld", rsp_vld, 0);
      checkOutput("rd_wait_paddr", PADDR, 64'h20);
      checkOutput("rd_wait_psel", PSEL, 1);
    end
    PREADY = 1'b1;
    tick();
    checkOutput("rd_rsp_vld", rsp_vld, 1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    checkOutput("rd_rsp_err", rsp_err, 0);
    tick();
    checkOutput("rd_done_req_rdy", req_rdy, 1);

    // Slave error on a write
    PSLVERR = 1'b1;
    applyStimulus(1'b1, 64'h30, 32'h5555_AAAA);
    tick();
    req_vld = 1'b0;
    tick();
    tick();
    checkOutput("err_rsp_vld", rsp_vld, 1);
    checkOutput("err_rsp_err", rsp_err, 1);
    checkOutput("err_rsp_timeout", rsp_timeout, 0);
    checkOutput("err_rsp_rdata", rsp_rdata, 0);
    tick();
    PSLVERR = 1'b0;

    // Timeout after 8 ACCESS cycles, then backpressure
    PREADY  = 1'b0;
    PRDATA  = 32'hDEAD_BEEF;
    rsp_rdy = 1'b0;
    applyStimulus(1'b0, 64'h40, 32'h0);
    tick();
    req_vld = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    checkOutput("to_access8_psel", PSEL, 1);
    checkOutput("to_access8_penable", PENABLE, 1);
    checkOutput("to_access8_rsp_vld", rsp_vld, 0);
    tick();
    checkOutput("to_rsp_vld", rsp_vld, 1);
    checkOutput("to_rsp_err", rsp_err, 1);
    checkOutput("to_rsp_timeout", rsp_timeout, 1);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);
    checkOutput("to_psel", PSEL, 0);
    checkOutput("to_penable", PENABLE, 0);
    PREADY = 1'b1;
    applyStimulus(1'b1, 64'h50, 32'hA5A5_A5A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      PREADY = 1'b0;
      checkOutput("bp_rsp_vld", rsp_vld, 1);
      checkOutput("bp_rsp_timeout", rsp_timeout, 1);
      checkOutput("bp_rsp_rdata", rsp_rdata, 0);
      checkOutput("bp_req_rdy", req_rdy, 0);
      checkOutput("bp_psel", PSEL, 0);
      checkOutput("bp_paddr", PADDR, 64'h40);
    end
    rsp_rdy = 1'b1;
    tick();
    checkOutput("bp_release_rsp_vld", rsp_vld, 0);
    checkOutput("bp_release_req_rdy", req_rdy, 1);
    checkOutput("bp_release_timeout_held", rsp_timeout, 1);
    tick();
    req_vld = 1'b0;
    checkOutput("bp_accept_psel", PSEL, 1);
    checkOutput("bp_accept_paddr", PADDR, 64'h50);
    checkOutput("bp_accept_pwrite", PWRITE, 1);
    PREADY = 1'b1;
    tick();
    tick();
    checkOutput("bp_next_rsp_vld", rsp_vld, 1);
    checkOutput("bp_next_rsp_timeout", rsp_timeout, 0);
    checkOutput("bp_next_rsp_err", rsp_err, 0);
    tick();

    // Reset while waiting in ACCESS
    PREADY = 1'b0;
    applyStimulus(1'b0, 64'h60, 32'h0);
    tick();
    req_vld = 1'b0;
    tick();
    tick();
    checkOutput("mid_penable", PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_psel", PSEL, 0);
    checkOutput("mid_rst_penable", PENABLE, 0);
    checkOutput("mid_rst_rsp_vld", rsp_vld, 0);
    checkOutput("mid_rst_req_rdy", req_rdy, 1);
    checkOutput("mid_rst_busy", busy, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    PRDATA  = 32'hCAFE_F00D;
    applyStimulus(1'b0, 64'h10, 32'h0);
    tick();
    req_vld = 1'b0;
    checkOutput("post_rst_paddr", PADDR, 64'h10);
    tick();
    tick();
    checkOutput("post_rst_rsp_vld", rsp_vld, 1);
    checkOutput("post_rst_rdata", rsp_rdata, 32'hCAFE_F00D);
    checkOutput("post_rst_err", rsp_err, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
